// File: rtl/dpram_copy_engine.sv
// Dual-port RAM copy engine: streams LEN words from SRC to DST, reading port A and
// writing port B one cycle later, choosing the copy direction so overlapping moves are safe.
module dpram_copy_engine #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW:0]   cmd_len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW:0]   words,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  input  logic [DW-1:0] doa,
  output logic          enb,
  output logic          web,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dib
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t        state, state_nxt;
  logic          accept;
  logic          rd_last;
  logic          desc_in;

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic          desc_q;
  logic [AW:0]   rd_idx;
  logic          abort_q;
  logic [AW:0]   words_q;

  logic          wr_vld_p1;
  logic [AW:0]   wr_idx_p1;

  // Address of element idx, walking up from base or down from base+len-1 (mod 2**AW).
  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                               input logic [AW:0]   idx,
                                               input logic [AW:0]   len,
                                               input logic          desc);
    logic [AW:0] ofs;
    ofs = desc ? (len - idx - LEN_ONE) : idx;
    return base + ofs[AW-1:0];
  endfunction

  assign accept  = cmd_valid && (state == S_IDLE);
  assign rd_last = (rd_idx == len_q - LEN_ONE);

  // Destination one step ahead of source across the wrap point must still run
  // descending (and vice versa), otherwise the read and write ports collide.
  always_comb begin
    desc_in = (cmd_dst > cmd_src);
    if ((cmd_src == ADDR_MAX) && (cmd_dst == '0))
      desc_in = 1'b1;
    else if ((cmd_src == '0) && (cmd_dst == ADDR_MAX))
      desc_in = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (rd_last || abort) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_vld_p1 <= 1'b0;
      words_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_vld_p1 <= (state == S_RUN);
      if (accept) begin
        words_q <= '0;
        abort_q <= 1'b0;
      end else begin
        if (wr_vld_p1) words_q <= words_q + LEN_ONE;
        if ((state == S_RUN) && abort && !rd_last) abort_q <= 1'b1;
      end
    end
  end

  // p0: command latch and read issue
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q  <= cmd_src;
      dst_q  <= cmd_dst;
      len_q  <= cmd_len;
      desc_q <= desc_in;
      rd_idx <= '0;
    end else if (state == S_RUN) begin
      rd_idx <= rd_idx + LEN_ONE;
    end
  end

  // p1: write of the element read in the previous cycle
  always_ff @(posedge clk) begin
    if (state == S_RUN) wr_idx_p1 <= rd_idx;
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign aborted   = done && abort_q;
  assign words     = words_q;

  assign ena   = (state == S_RUN);
  assign wea   = 1'b0;
  assign addra = ena ? elem_addr(src_q, rd_idx, len_q, desc_q) : '0;

  assign enb   = wr_vld_p1;
  assign web   = wr_vld_p1;
  assign addrb = enb ? elem_addr(dst_q, wr_idx_p1, len_q, desc_q) : '0;
  assign dib   = enb ? doa : '0;

endmodule
